// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store initiator: base+offset addressing, range check, strobed 64x16 memory access, valid/ready response
module lsu_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] ea;
  logic              ea_err;
  logic              accept;

  // Effective address wraps modulo 2^DATA_W; any bit above the word address is out of range.
  assign ea        = req_base + {{(DATA_W-ADDR_W){req_offset[ADDR_W-1]}}, req_offset};
  assign ea_err    = |ea[DATA_W-1:ADDR_W];
  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (ea_err) begin
            state_nxt = RESP;
          end else if (req_we) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      WRITE:   state_nxt = RESP;
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered at accept so the memory never sees a combinational path from req_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      rsp_rdata   <= '0;
      rsp_tag     <= '0;
      rsp_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      mem_wr_en <= accept && !ea_err && req_we;
      mem_rd_en <= accept && !ea_err && !req_we;
      if (accept) begin
        rsp_tag   <= req_tag;
        rsp_err   <= ea_err;
        rsp_rdata <= '0;
        if (!ea_err) begin
          mem_address <= ea[ADDR_W-1:0];
        end
        if (!ea_err && req_we) begin
          mem_wdata <= req_wdata;
        end
        if (ea_err && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end
      if (state == CAPTURE) begin
        rsp_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl with a transaction-level latency model
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_base = '0;
  logic [5:0]  req_offset = '0;
  logic [15:0] req_wdata = '0;
  logic [2:0]  req_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_rdata;
  logic [2:0]  rsp_tag;
  logic        rsp_err;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [5:0]  mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [7:0]  err_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [15:0] mem    [64];
  logic [15:0] shadow [64];

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory with one-cycle registered read
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_address] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding transaction described by kind, accept cycle and latency
  localparam int K_ST = 0, K_LD = 1, K_ER = 2;
  bit          m_busy = 0;
  int          m_kind = 0;
  int          m_acc = 0;
  int          m_lat = 0;
  int          m_err = 0;
  logic [5:0]  m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;
  logic [2:0]  m_tag = '0;
  int          off_s;
  int          eai;
  bit          exp_rv, exp_wr, exp_rd;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_err  = 0;
    end else begin
      exp_rv = m_busy && (cyc >= m_acc + m_lat);
      exp_wr = m_busy && (m_kind == K_ST) && (cyc == m_acc + 1);
      exp_rd = m_busy && (m_kind == K_LD) && (cyc == m_acc + 1);
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_wr));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
      chk("err_count", 32'(err_count), 32'(m_err));
      if (exp_wr) begin
        chk("wr_address", 32'(mem_address), 32'(m_addr));
        chk("wr_data", 32'(mem_wdata), 32'(m_wdata));
      end
      if (exp_rd) chk("rd_address", 32'(mem_address), 32'(m_addr));
      if (exp_rv) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("rsp_tag", 32'(rsp_tag), 32'(m_tag));
        chk("rsp_err", 32'(rsp_err), 32'(m_kind == K_ER));
      end
      if (exp_rv && rsp_ready) begin
        m_busy = 0;
      end else if (!m_busy && req_valid) begin
        off_s  = req_offset[5] ? int'(req_offset) - 64 : int'(req_offset);
        eai    = (int'(req_base) + off_s + 65536) % 65536;
        m_busy = 1;
        m_acc  = cyc;
        m_tag  = req_tag;
        m_addr = eai[5:0];
        if (eai > 63) begin
          m_kind  = K_ER;
          m_lat   = 1;
          m_rdata = '0;
          if (m_err < 255) m_err++;
        end else if (req_we) begin
          m_kind  = K_ST;
          m_lat   = 2;
          m_wdata = req_wdata;
          m_rdata = '0;
          shadow[eai[5:0]] = req_wdata;
        end else begin
          m_kind  = K_LD;
          m_lat   = 3;
          m_rdata = shadow[eai[5:0]];
        end
      end
    end
  end

  task automatic start_req(input logic we, input logic [15:0] base, input logic [5:0] off,
                           input logic [15:0] wd, input logic [2:0] tag,
                           output logic s_wr, output logic s_rd, output logic [5:0] s_addr);
    int n;
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = we; req_base = base; req_offset = off;
    req_wdata = wd; req_tag = tag;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #2;
    req_valid = 1'b0;
    s_wr = mem_wr_en;
    s_rd = mem_rd_en;
    s_addr = mem_address;
  endtask

  task automatic wait_rsp(output int lat, output logic [15:0] rd, output logic [2:0] tg, output logic er);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    rd = rsp_rdata;
    tg = rsp_tag;
    er = rsp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s_wr, s_rd, er;
    logic [5:0]  s_addr;
    logic [15:0] rd;
    logic [2:0]  tg;
    int          lat;

    for (int i = 0; i < 64; i++) begin
      mem[i]    = 16'(i * 257) ^ 16'hA5A5;
      shadow[i] = 16'(i * 257) ^ 16'hA5A5;
    end
    mem[6'h1B]    = 16'h1234;
    shadow[6'h1B] = 16'h1234;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_wr_rd", 32'({mem_wr_en, mem_rd_en}), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Store 0x0010 + 5 -> 0x15
    start_req(1'b1, 16'h0010, 6'd5, 16'hBEEF, 3'd2, s_wr, s_rd, s_addr);
    chk("st_wr_strobe", 32'({s_wr, s_rd}), 32'b10);
    chk("st_addr", 32'(s_addr), 32'h15);
    wait_rsp(lat, rd, tg, er);
    chk("st_latency", 32'(lat), 32'd2);
    chk("st_rsp", 32'({rd, tg, er}), 32'({16'h0000, 3'd2, 1'b0}));
    chk("model_shadow_15", 32'(shadow[6'h15]), 32'hBEEF);
    @(posedge clk); #2;

    // Load 0x0020 - 5 -> 0x1B
    start_req(1'b0, 16'h0020, 6'b111011, 16'h0, 3'd5, s_wr, s_rd, s_addr);
    chk("ld_rd_strobe", 32'({s_wr, s_rd}), 32'b01);
    chk("ld_addr", 32'(s_addr), 32'h1B);
    wait_rsp(lat, rd, tg, er);
    chk("ld_latency", 32'(lat), 32'd3);
    chk("ld_rsp", 32'({rd, tg, er}), 32'({16'h1234, 3'd5, 1'b0}));
    @(posedge clk); #2;

    // Range errors: 0x0040 and 0xFFFF
    start_req(1'b0, 16'h003F, 6'd1, 16'h0, 3'd1, s_wr, s_rd, s_addr);
    chk("er1_no_strobe", 32'({s_wr, s_rd}), 32'b00);
    wait_rsp(lat, rd, tg, er);
    chk("er1_latency", 32'(lat), 32'd1);
    chk("er1_rsp", 32'({rd, tg, er}), 32'({16'h0000, 3'd1, 1'b1}));
    chk("er1_count", 32'(err_count), 32'd1);
    @(posedge clk); #2;
    start_req(1'b1, 16'h0000, 6'h3F, 16'h5555, 3'd6, s_wr, s_rd, s_addr);
    chk("er2_no_strobe", 32'({s_wr, s_rd}), 32'b00);
    wait_rsp(lat, rd, tg, er);
    chk("er2_rsp", 32'({rd, tg, er}), 32'({16'h0000, 3'd6, 1'b1}));
    chk("er2_count", 32'(err_count), 32'd2);
    chk("model_err_2", 32'(m_err), 32'd2);
    @(posedge clk); #2;

    // Top word 0x3F: store then load back via 0x0040 - 1
    start_req(1'b1, 16'h003F, 6'd0, 16'hCAFE, 3'd3, s_wr, s_rd, s_addr);
    chk("top_st_addr", 32'(s_addr), 32'h3F);
    wait_rsp(lat, rd, tg, er);
    @(posedge clk); #2;
    start_req(1'b0, 16'h0040, 6'h3F, 16'h0, 3'd4, s_wr, s_rd, s_addr);
    wait_rsp(lat, rd, tg, er);
    chk("top_ld_rsp", 32'({rd, tg, er}), 32'({16'hCAFE, 3'd4, 1'b0}));
    @(posedge clk); #2;

    // Backpressure on a load response with the next request already waiting
    rsp_ready = 1'b0;
    start_req(1'b0, 16'h0020, 6'b111011, 16'h0, 3'd7, s_wr, s_rd, s_addr);
    wait_rsp(lat, rd, tg, er);
    chk("bp_latency", 32'(lat), 32'd3);
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = 1'b1; req_base = 16'h0001; req_offset = 6'd1;
    req_wdata = 16'h7777; req_tag = 3'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'({rsp_valid, req_ready, rsp_rdata, rsp_tag, rsp_err}),
          32'({1'b1, 1'b0, 16'h1234, 3'd7, 1'b0}));
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_after_hs", 32'(req_ready), 32'd1);
    @(posedge clk); #2;
    req_valid = 1'b0;
    chk("bp_next_wr", 32'({mem_wr_en, mem_address}), 32'({1'b1, 6'h02}));
    wait_rsp(lat, rd, tg, er);
    chk("bp_next_latency", 32'(lat), 32'd2);
    @(posedge clk); #2;

    // Asynchronous reset while in READ
    start_req(1'b0, 16'h0010, 6'd0, 16'h0, 3'd2, s_wr, s_rd, s_addr);
    chk("rst_in_read", 32'(s_rd), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", 32'({mem_rd_en, rsp_valid, req_ready, err_count}),
        32'({1'b0, 1'b0, 1'b1, 8'd0}));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      start_req(i[0], 16'h0040 + 16'(i), 6'd0, 16'h0, 3'(i), s_wr, s_rd, s_addr);
      wait_rsp(lat, rd, tg, er);
      @(posedge clk); #2;
    end
    @(negedge clk);
    chk("sat_err_count", 32'(err_count), 32'd255);
    chk("model_err_sat", 32'(m_err), 32'd255);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store initiator between the CPU datapath and the 64×16 data memory. It accepts one load or store request at a time from the execute stage and forms the effective address as base + sign-extended offset. It range-checks that address, drives the memory's write/read strobes and 6-bit address, and captures read data after the memory's one-cycle read latency. Results return to writeback over a valid/ready response channel.

## Interface
- `DATA_W`, 16, data and base-register width
- `ADDR_W`, 6, memory address width (depth 2^ADDR_W = 64 words)
- `TAG_W`, 3, destination-register tag carried from request to response
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request (high only in IDLE)
- `req_we`  in  1  1 = store, 0 = load
- `req_base`  in  DATA_W  base register value
- `req_offset`  in  ADDR_W  two's-complement offset
- `req_wdata`  in  DATA_W  store data
- `req_tag`  in  TAG_W  destination tag
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_rdata`  out  DATA_W  load data (0 for stores and errors)
- `rsp_tag`  out  TAG_W  tag of the completed request
- `rsp_err`  out  1  effective address out of range; no memory access made
- `mem_wr_en`  out  1  memory write strobe
- `mem_rd_en`  out  1  memory read strobe
- `mem_address`  out  ADDR_W  memory word address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory registered read data
- `err_count`  out  8  saturating count of errored requests

## Operation
- FSM states: IDLE, WRITE, READ, CAPTURE, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch we/wdata/tag and compute `ea = req_base + sext(req_offset)`, 16-bit, wrapping modulo 2^16.
  - Error is `ea[15:ADDR_W] != 0`.
  - On error, go to RESP with `rsp_err`=1 and increment `err_count`, saturating at 255.
  - Otherwise latch `mem_address` = `ea[ADDR_W-1:0]` and go to WRITE if we, else READ.
- WRITE
  - `mem_wr_en`=1 for exactly one cycle, with `mem_wdata` = latched wdata.
  - Next state RESP.
- READ
  - `mem_rd_en`=1 for exactly one cycle.
  - Next state CAPTURE.
- CAPTURE
  - Strobes low; latch `mem_rdata` into `rsp_rdata`.
  - Next state RESP.
- RESP
  - `rsp_valid`=1; `rsp_rdata`, `rsp_tag` and `rsp_err` are held stable.
  - Leave to IDLE on the edge where `rsp_ready`=1.
- Strobes
  - `mem_wr_en` and `mem_rd_en` are never high together.
  - Both are low outside WRITE and READ.
  - Both are driven from registers, so there are no combinational paths from `req_*` to `mem_*`.
- Requests are not accepted in RESP. There is no overlap: one outstanding request.
- Reset clears all registers and forces IDLE.
  - Reset values: all outputs 0 except `req_ready`=1. `err_count`=0.
  - A request in flight during reset is dropped with no response. A store in WRITE during reset is not guaranteed to reach memory.

## Timing
- E0 is the edge where `req_valid && req_ready`.
- Store
  - `mem_wr_en` is high in the cycle after E0; memory writes at E1.
  - `rsp_valid` rises after E1.
  - Earliest accept at E2, earliest next request at E3. Minimum 3 cycles per store.
- Load
  - `mem_rd_en` is high after E0; memory updates data_out at E1.
  - CAPTURE latches at E2, `rsp_valid` rises after E2, earliest accept at E3. Minimum 4 cycles per load.
- Error
  - `rsp_valid` rises after E0 with no strobe activity.
  - Earliest accept at E1. Minimum 2 cycles.
- With `rsp_ready` held low, RESP persists indefinitely and outputs are stable.

## Test plan
- **Reset:** assert `rst` mid-READ → immediately `mem_rd_en`=0, `rsp_valid`=0, `req_ready`=1, `err_count`=0.
- **Store:** store base=0x0010, offset=+5, wdata=0xBEEF, tag=2 → one-cycle `mem_wr_en` at address 0x15. `rsp_valid` two cycles after accept with tag=2, err=0, rdata=0.
- **Load:** load base=0x0020, offset=−5 (6'b111011) → `mem_rd_en` at address 0x1B. Memory returns 0x1234 → `rsp_rdata`=0x1234, `rsp_valid` three cycles after accept.
- **Range error:** base=0x003F, offset=+1 (ea=0x0040) → no strobes, `rsp_err`=1 one cycle after accept, `err_count`=1. Base=0x0000, offset=−1 (ea=0xFFFF) → error as well.
- **Backpressure:** `rsp_ready` low for 5 cycles during a load response → `rsp_*` stable and `req_ready`=0 throughout. The new `req_valid` is accepted only after the response handshake.
- **Saturation:** 300 errored requests → `err_count` stops at 255.
